// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory handshake, stalls upstream
// while an access is outstanding, and registers the MEM/WB latch. Optional macro: MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_regwrite_in,
  input  logic [1:0]         mem_memtoreg_in,
  input  logic               mem_memread_in,
  input  logic               mem_memwrite_in,
  input  logic [DATA_W-1:0]  mem_alu_in,
  input  logic [DATA_W-1:0]  mem_wrdata_in,
  input  logic [DATA_W-1:0]  mem_link_in,
  input  logic [RADDR_W-1:0] mem_regwraddr_in,
  output logic               mem_regwrite,
  output logic               mem_memread,
  output logic [RADDR_W-1:0] mem_regwraddr,
  output logic               stall,
  output logic               dm_req,
  output logic               dm_we,
  output logic [DATA_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  input  logic [DATA_W-1:0]  dm_rdata,
  input  logic               dm_ack,
  output logic               wb_regwrite,
  output logic [RADDR_W-1:0] wb_regwraddr,
  output logic [DATA_W-1:0]  wb_regwrdata,
  output logic               mem_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic [1:0] SEL_LINK = 2'b10;

  logic [0:0]         state, state_nx;
  logic               dm_req_nx, dm_we_nx;
  logic [DATA_W-1:0]  dm_addr_nx, dm_wdata_nx;
  logic               wb_regwrite_nx;
  logic [RADDR_W-1:0] wb_regwraddr_nx;
  logic [DATA_W-1:0]  wb_regwrdata_nx;
  logic               acc, is_load, is_store;
  logic [DATA_W-1:0]  wb_data_sel;
  logic               timeout_hit;

  // Forwarding-unit taps are pure wires.
  assign mem_regwrite  = mem_regwrite_in;
  assign mem_memread   = mem_memread_in;
  assign mem_regwraddr = mem_regwraddr_in;

  // read+write together executes as a store only.
  assign acc      = mem_memread_in | mem_memwrite_in;
  assign is_store = mem_memwrite_in;
  assign is_load  = mem_memread_in & ~mem_memwrite_in;

  // Writeback data select; stores always carry the ALU value, reserved code falls back to ALU.
  always_comb begin
    wb_data_sel = mem_alu_in;
    if (is_load) begin
      wb_data_sel = dm_rdata;
    end else if (!is_store && mem_memtoreg_in == SEL_LINK) begin
      wb_data_sel = mem_link_in;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // cnt holds the number of completed no-ack ACCESS cycles, so the TIMEOUT-th one aborts.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt, cnt_nx;

  assign timeout_hit = (state == ACCESS) && !dm_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign cnt_nx      = ((state == ACCESS) && !dm_ack && !timeout_hit) ? cnt + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      mem_err <= mem_err | timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // Next-state, memory-port and MEM/WB latch update.
  always_comb begin
    state_nx        = state;
    dm_req_nx       = dm_req;
    dm_we_nx        = dm_we;
    dm_addr_nx      = dm_addr;
    dm_wdata_nx     = dm_wdata;
    wb_regwrite_nx  = wb_regwrite;
    wb_regwraddr_nx = wb_regwraddr;
    wb_regwrdata_nx = wb_regwrdata;
    stall           = 1'b0;

    case (state)
      IDLE: begin
        if (acc) begin
          stall          = 1'b1;
          dm_req_nx      = 1'b1;
          dm_we_nx       = mem_memwrite_in;
          dm_addr_nx     = mem_alu_in;
          dm_wdata_nx    = mem_wrdata_in;
          wb_regwrite_nx = 1'b0;
          state_nx       = ACCESS;
        end else begin
          wb_regwrite_nx  = mem_regwrite_in;
          wb_regwraddr_nx = mem_regwraddr_in;
          wb_regwrdata_nx = wb_data_sel;
        end
      end
      ACCESS: begin
        stall = ~dm_ack & ~timeout_hit;
        if (dm_ack) begin
          wb_regwrite_nx  = mem_regwrite_in & ~(mem_memread_in & mem_memwrite_in);
          wb_regwraddr_nx = mem_regwraddr_in;
          wb_regwrdata_nx = wb_data_sel;
          dm_req_nx       = 1'b0;
          state_nx        = IDLE;
        end else if (timeout_hit) begin
          wb_regwrite_nx  = 1'b0;
          wb_regwraddr_nx = mem_regwraddr_in;
          wb_regwrdata_nx = mem_alu_in;
          dm_req_nx       = 1'b0;
          state_nx        = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      wb_regwrite  <= 1'b0;
      wb_regwraddr <= '0;
      wb_regwrdata <= '0;
    end else begin
      state        <= state_nx;
      dm_req       <= dm_req_nx;
      dm_we        <= dm_we_nx;
      dm_addr      <= dm_addr_nx;
      dm_wdata     <= dm_wdata_nx;
      wb_regwrite  <= wb_regwrite_nx;
      wb_regwraddr <= wb_regwraddr_nx;
      wb_regwrdata <= wb_regwrdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: driver pushes expected MEM/WB records, a negedge monitor
// pops one whenever the stage consumed an instruction (stall low across an edge).
module tb_mem_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned TB_TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwrite_in, memread_in, memwrite_in;
  logic [1:0]    memtoreg_in;
  logic [DW-1:0] alu_in, wrdata_in, link_in;
  logic [RW-1:0] regwraddr_in;
  logic          mem_regwrite, mem_memread, stall;
  logic [RW-1:0] mem_regwraddr;
  logic          dm_req, dm_we, dm_ack;
  logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
  logic          wb_regwrite, mem_err;
  logic [RW-1:0] wb_regwraddr;
  logic [DW-1:0] wb_regwrdata;

  mem_stage #(.DATA_W(DW), .RADDR_W(RW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_regwrite_in(regwrite_in), .mem_memtoreg_in(memtoreg_in),
    .mem_memread_in(memread_in), .mem_memwrite_in(memwrite_in),
    .mem_alu_in(alu_in), .mem_wrdata_in(wrdata_in), .mem_link_in(link_in),
    .mem_regwraddr_in(regwraddr_in),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_regwraddr(mem_regwraddr),
    .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_regwrite(wb_regwrite), .wb_regwraddr(wb_regwraddr), .wb_regwrdata(wb_regwrdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [1:0]    m2r;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [DW-1:0] link;
    logic [RW-1:0] rd;
  } instr_t;

  typedef struct {
    logic          rw;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  pend   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction on the register file.
  function automatic wb_t ref_wb(input instr_t i, input logic [DW-1:0] rdata);
    wb_t w;
    w.rd = i.rd;
    if (i.wr_en) begin
      w.rw = i.rw && !i.rd_en;
      w.data = i.alu;
    end else if (i.rd_en) begin
      w.rw = i.rw;
      w.data = rdata;
    end else begin
      w.rw = i.rw;
      w.data = (i.m2r == 2'b10) ? i.link : i.alu;
    end
    return w;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i = '{rw: 1'b0, m2r: 2'b00, rd_en: 1'b0, wr_en: 1'b0, alu: '0, wdata: '0, link: '0, rd: '0};
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    i = nop();
    k = int'($urandom_range(0, 4));
    i.rw = 1'($urandom);
    i.alu = 16'($urandom);
    i.wdata = 16'($urandom);
    i.link = 16'($urandom);
    i.rd = 4'($urandom);
    case (k)
      0: i.m2r = 2'b00;
      1: i.m2r = 2'b11;
      2: i.m2r = 2'b10;
      3: begin i.m2r = 2'b01; i.rd_en = 1'b1; end
      default: begin i.wr_en = 1'b1; i.rd_en = ($urandom_range(0, 3) == 0); end
    endcase
    return i;
  endfunction

  task automatic drive(input instr_t i);
    regwrite_in = i.rw; memtoreg_in = i.m2r; memread_in = i.rd_en; memwrite_in = i.wr_en;
    alu_in = i.alu; wrdata_in = i.wdata; link_in = i.link; regwraddr_in = i.rd;
  endtask

  // Entered and left at posedge+1; presents one instruction until it is consumed.
  task automatic run_instr(input instr_t i, input int ack_dly, input logic [DW-1:0] rdata);
    int hi;
    hi = 0;
    drive(i);
    exp_q.push_back(ref_wb(i, rdata));
    #1;
    chk("fwd_regwrite", mem_regwrite, i.rw);
    chk("fwd_memread", mem_memread, i.rd_en);
    chk("fwd_regwraddr", mem_regwraddr, i.rd);
    if (!(i.rd_en || i.wr_en)) begin
      chk("stall_alu", stall, 0);
      @(posedge clk); #1;
    end else begin
      if (stall) hi++;
      @(posedge clk); #1;
      chk("dm_req_on", dm_req, 1);
      chk("dm_we", dm_we, i.wr_en);
      chk("dm_addr", dm_addr, i.alu);
      if (i.wr_en) chk("dm_wdata", dm_wdata, i.wdata);
      for (int k = 0; k < ack_dly; k++) begin
        if (stall) hi++;
        @(posedge clk); #1;
        chk("dm_req_hold", dm_req, 1);
        chk("dm_addr_hold", dm_addr, i.alu);
      end
      dm_ack = 1'b1;
      dm_rdata = rdata;
      #1;
      chk("stall_ack", stall, 0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      dm_rdata = 16'($urandom);
      chk("dm_req_off", dm_req, 0);
      chk("stall_cycles", 32'(hi), 32'(1 + ack_dly));
    end
  endtask

  // Monitor: an edge with stall low retires the presented instruction into MEM/WB.
  always @(negedge clk) begin : monitor
    wb_t e;
    if (mon_en) begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_regwrite", wb_regwrite, e.rw);
          if (e.rw) begin
            chk("wb_regwraddr", wb_regwraddr, e.rd);
            chk("wb_regwrdata", wb_regwrdata, e.data);
          end
        end
      end
      pend = !stall;
    end else begin
      pend = 1'b0;
    end
  end

  initial begin
    instr_t t;
    rst = 1'b1;
    dm_ack = 1'b0;
    dm_rdata = '0;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_wb_regwraddr", wb_regwraddr, 0);
    chk("rst_wb_regwrdata", wb_regwrdata, 0);
    chk("rst_mem_err", mem_err, 0);

    // Stale ack arriving in IDLE right after reset is ignored.
    dm_ack = 1'b1;
    dm_rdata = 16'hFACE;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("stale_ack_req", dm_req, 0);
    chk("stale_ack_wb", wb_regwrite, 0);
    chk("stale_ack_data", wb_regwrdata, 0);
    mon_en = 1'b1;

    t = nop(); t.rw = 1'b1; t.alu = 16'h1234; t.rd = 4'd5;
    run_instr(t, 0, '0);
    t = nop(); t.rw = 1'b1; t.m2r = 2'b01; t.rd_en = 1'b1; t.alu = 16'h0040; t.rd = 4'd3;
    run_instr(t, 0, 16'hBEEF);
    t = nop(); t.wr_en = 1'b1; t.alu = 16'h0010; t.wdata = 16'hA5A5; t.rd = 4'd1;
    run_instr(t, 4, 16'h5555);
    t = nop(); t.rw = 1'b1; t.m2r = 2'b10; t.link = 16'h0101; t.alu = 16'h7777; t.rd = 4'd7;
    run_instr(t, 0, '0);
    t = nop(); t.rw = 1'b1; t.m2r = 2'b01; t.rd_en = 1'b1; t.wr_en = 1'b1; t.alu = 16'h0022;
    t.wdata = 16'h3C3C; t.rd = 4'd9;
    run_instr(t, 2, 16'h9999);

    for (int n = 0; n < 200; n++) begin
      run_instr(rand_instr(), int'($urandom_range(0, 6)), 16'($urandom));
    end

    // Drain the scoreboard, then pause it for the reset-in-ACCESS scenario.
    drive(nop());
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("sb_drain", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(posedge clk); #1;

    t = nop(); t.rw = 1'b1; t.m2r = 2'b01; t.rd_en = 1'b1; t.alu = 16'h0200; t.rd = 4'd9;
    drive(t);
    @(posedge clk); #1;
    chk("rstacc_req_before", dm_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstacc_req", dm_req, 0);
    chk("rstacc_addr", dm_addr, 0);
    chk("rstacc_wb_regwrite", wb_regwrite, 0);
    chk("rstacc_wb_regwraddr", wb_regwraddr, 0);
    chk("rstacc_wb_regwrdata", wb_regwrdata, 0);
    drive(nop());
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b1;
    dm_rdata = 16'hDEAD;
    #1;
    chk("rstacc_stall", stall, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("rstacc_post_req", dm_req, 0);
    chk("rstacc_post_wb", wb_regwrite, 0);
    chk("rstacc_post_data", wb_regwrdata, 0);
    mon_en = 1'b1;

`ifdef MEM_TIMEOUT_EN
    t = nop(); t.rw = 1'b1; t.m2r = 2'b01; t.rd_en = 1'b1; t.alu = 16'h0300; t.rd = 4'd2;
    drive(t);
    exp_q.push_back('{rw: 1'b0, rd: t.rd, data: '0});
    #1;
    chk("to_stall_idle", stall, 1);
    @(posedge clk); #1;
    for (int k = 1; k < int'(TB_TIMEOUT); k++) begin
      chk("to_stall_wait", stall, 1);
      @(posedge clk); #1;
    end
    chk("to_stall_abort", stall, 0);
    chk("to_err_before", mem_err, 0);
    @(posedge clk); #1;
    chk("to_req", dm_req, 0);
    chk("to_err", mem_err, 1);
    run_instr(nop(), 0, '0);
    chk("to_err_sticky", mem_err, 1);
`else
    t = nop(); t.rw = 1'b1; t.m2r = 2'b01; t.rd_en = 1'b1; t.alu = 16'h0300; t.rd = 4'd2;
    run_instr(t, 300, 16'h4321);
    chk("no_err", mem_err, 0);
`endif

    t = nop(); t.rw = 1'b1; t.alu = 16'h0F0F; t.rd = 4'd15;
    run_instr(t, 0, '0);
    drive(nop());
    @(negedge clk); #1;
    chk("sb_final_drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
